// File: rtl/tpu_fp_pkg.sv
// Shared FP32 constants, FSM state encoding and small helpers for the
// tpu floating-point recomposition path.
package tpu_fp_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int EXP_BIAS = 127;
   localparam int INT_W    = 11;   // signed width of the converted n and the exponent sum

   localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
   localparam logic [FP_W-1:0] POS_INF = 32'h7F80_0000;

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      ADD,
      DENORM,
      DONE
   } state_t;

   // Leading-zero count of a fraction field; 23 when the field is all zero.
   function automatic logic [4:0] lzc_frac(input logic [FRAC_W-1:0] f);
      logic [4:0] c;
      c = 5'd23;
      for (int i = 0; i < FRAC_W; i++) begin
         if (f[i]) c = 5'(FRAC_W - 1 - i);
      end
      return c;
   endfunction

endpackage

// File: rtl/fp32_to_int_trunc.sv
// FP32 -> saturated signed integer, truncating toward zero.
// NaN/inf are flagged separately; the integer output is don't-care for them.
module fp32_to_int_trunc
   import tpu_fp_pkg::*;
#(
   parameter int N_SAT = 300
) (
   input  logic [FP_W-1:0]         f,
   output logic signed [INT_W-1:0] val,
   output logic                    is_nan,
   output logic                    is_inf
);

   localparam logic [FRAC_W:0]  SAT_MAG  = (FRAC_W+1)'(N_SAT);
   localparam logic [INT_W-1:0] SAT_VAL  = INT_W'(N_SAT);
   // exponent field at which the whole 24-bit significand is integer
   localparam logic [EXP_W-1:0] EXP_INT  = EXP_W'(EXP_BIAS + FRAC_W);
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(EXP_BIAS);

   logic [EXP_W-1:0]  ef;
   logic [FRAC_W-1:0] fr;
   logic [FRAC_W:0]   mag;
   logic [INT_W-1:0]  mag_c;

   // Decode, shift the significand down to its integer part, then clamp.
   always_comb begin
      ef     = f[FP_W-2 -: EXP_W];
      fr     = f[FRAC_W-1:0];
      is_nan = (ef == '1) && (fr != '0);
      is_inf = (ef == '1) && (fr == '0);
      mag    = '0;
      if (ef < EXP_ONE)       mag = '0;                      // |f| < 1
      else if (ef >= EXP_INT) mag = '1;                      // far beyond any clamp
      else                    mag = {1'b1, fr} >> (EXP_INT - ef);
      mag_c  = (mag > SAT_MAG) ? SAT_VAL : mag[INT_W-1:0];
      val    = f[FP_W-1] ? $signed(-mag_c) : $signed(mag_c);
   end

endmodule

// File: rtl/scale_by_pow2.sv
// FP32 recomposition: result = x * 2^n, one operation at a time.
// Subnormal results are produced by shifting the significand one bit per cycle.
module scale_by_pow2
   import tpu_fp_pkg::*;
#(
   parameter bit FLUSH_SUBNORM_IN = 1'b1,
   parameter int N_SAT            = 300
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [FP_W-1:0] x,
   input  logic [FP_W-1:0] n,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FP_W-1:0] result,
   output logic            overflow,
   output logic            underflow,
   output logic            invalid
);

   state_t state_q, state_d;

   logic [FP_W-1:0]         x_q, n_q;
   logic signed [INT_W-1:0] nint_q, e_q;
   logic                    n_nan_q, n_inf_q, sx_q;
   logic [FRAC_W:0]         mant_q;

   logic signed [INT_W-1:0] conv_val;
   logic                    conv_nan, conv_inf;

   // Combinational n conversion; its output is captured during CONV.
   fp32_to_int_trunc #(.N_SAT(N_SAT)) u_conv (
      .f      (n_q),
      .val    (conv_val),
      .is_nan (conv_nan),
      .is_inf (conv_inf)
   );

   logic [EXP_W-1:0]        x_ef;
   logic [FRAC_W-1:0]       x_fr;
   logic                    x_nan, x_inf, x_sub, x_zero, special, go_denorm;
   logic [4:0]              x_lz;
   logic signed [INT_W-1:0] x_e, e_sum;
   logic [FRAC_W:0]         x_m, mant_shr;

   // Classify x and form the exponent sum. A subnormal x that is not flushed
   // is normalised first so the common normal/denorm paths apply unchanged.
   always_comb begin
      x_ef      = x_q[FP_W-2 -: EXP_W];
      x_fr      = x_q[FRAC_W-1:0];
      x_nan     = (x_ef == '1) && (x_fr != '0);
      x_inf     = (x_ef == '1) && (x_fr == '0);
      x_sub     = (x_ef == '0) && (x_fr != '0);
      x_zero    = (x_ef == '0) && ((x_fr == '0) || FLUSH_SUBNORM_IN);
      x_lz      = lzc_frac(x_fr);
      x_e       = {{(INT_W-EXP_W){1'b0}}, x_ef};
      x_m       = {1'b1, x_fr};
      if (x_sub) begin
         x_e = -$signed({{(INT_W-5){1'b0}}, x_lz});
         x_m = {1'b0, x_fr} << (x_lz + 5'd1);
      end
      e_sum     = x_e + nint_q;
      special   = x_nan | n_nan_q | n_inf_q | x_inf | x_zero;
      go_denorm = !special && (e_sum <= 11'sd0) && (e_sum >= -11'sd22);
      mant_shr  = mant_q >> 1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = CONV;
         CONV:    state_d = ADD;
         ADD:     state_d = go_denorm ? DENORM : DONE;
         DENORM:  if (e_q == 11'sd0) state_d = DONE;   // this shift lands e on 1
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);

   // Datapath: operand capture, n conversion, exponent add and the serial
   // denorm shifter. Result and flags only change in ADD/DENORM, so they
   // stay put for the whole DONE residency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         n_q       <= '0;
         nint_q    <= '0;
         n_nan_q   <= 1'b0;
         n_inf_q   <= 1'b0;
         e_q       <= '0;
         mant_q    <= '0;
         sx_q      <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         invalid   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q <= x;
                  n_q <= n;
               end
            end
            CONV: begin
               nint_q  <= conv_val;
               n_nan_q <= conv_nan;
               n_inf_q <= conv_inf;
            end
            ADD: begin
               overflow  <= 1'b0;
               underflow <= 1'b0;
               invalid   <= 1'b0;
               sx_q      <= x_q[FP_W-1];
               e_q       <= e_sum;
               mant_q    <= x_m;
               if (x_nan || n_nan_q || n_inf_q) begin
                  result  <= QNAN;
                  invalid <= 1'b1;
               end else if (x_inf) begin
                  result <= {x_q[FP_W-1], POS_INF[FP_W-2:0]};
               end else if (x_zero) begin
                  result <= {x_q[FP_W-1], {(FP_W-1){1'b0}}};
               end else if (e_sum >= 11'sd255) begin
                  result   <= {x_q[FP_W-1], POS_INF[FP_W-2:0]};
                  overflow <= 1'b1;
               end else if (e_sum >= 11'sd1) begin
                  result <= {x_q[FP_W-1], e_sum[EXP_W-1:0], x_m[FRAC_W-1:0]};
               end else begin
                  // too small even for a subnormal: flush now, no shifting
                  underflow <= 1'b1;
                  if (!go_denorm) result <= {x_q[FP_W-1], {(FP_W-1){1'b0}}};
               end
            end
            DENORM: begin
               mant_q <= mant_shr;
               e_q    <= e_q + 11'sd1;
               if (e_q == 11'sd0)
                  result <= {sx_q, {EXP_W{1'b0}}, mant_shr[FRAC_W-1:0]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_scale_by_pow2.sv
// Directed bench for scale_by_pow2: hand-computed vectors, latency,
// output hold under back-pressure, and asynchronous reset mid-operation.
module tb_scale_by_pow2;

   logic        clk, rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] x, n, result;
   logic        overflow, underflow, invalid;

   int total = 0;
   int fails = 0;

   scale_by_pow2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .n         (n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Issue one op (called #1 after a posedge while idle), measure latency,
   // check result and {overflow,underflow,invalid}, then complete the handshake.
   task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] nv,
                         input logic [31:0] er, input logic [2:0] ef, input int elat,
                         input bit early);
      int cnt;
      in_valid  = 1'b1;
      x         = xv;
      n         = nv;
      out_ready = early;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x        = '0;
      n        = '0;
      chk({tag, ".busy"}, 32'(in_ready), 32'd0);
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, ".lat"}, 32'(cnt), 32'(elat));
      chk({tag, ".res"}, result, er);
      chk({tag, ".flags"}, 32'({overflow, underflow, invalid}), 32'(ef));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".ret"}, 32'({out_valid, in_ready}), 32'b01);
   endtask

   initial begin
      int  cnt;
      bit  seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      n         = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result", result, 32'h0000_0000);
      chk("rst.flags", 32'({overflow, underflow, invalid}), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // flags order: {overflow, underflow, invalid}
      run_op("m1.25x4",    32'h3FA0_0000, 32'h4000_0000, 32'h40A0_0000, 3'b000, 3,  1'b0);
      run_op("m100",       32'h3FC8_0000, 32'h40C0_0000, 32'h42C8_0000, 3'b000, 3,  1'b1);
      run_op("m950",       32'h3FED_8000, 32'h4110_0000, 32'h446D_8000, 3'b000, 3,  1'b0);
      run_op("ntrunc-2.5", 32'h3FA0_0000, 32'hC020_0000, 32'h3EA0_0000, 3'b000, 3,  1'b0);
      run_op("ntrunc0.75", 32'h3FA0_0000, 32'h3F40_0000, 32'h3FA0_0000, 3'b000, 3,  1'b0);
      run_op("e254",       32'h3F80_0000, 32'h42FE_0000, 32'h7F00_0000, 3'b000, 3,  1'b0);
      run_op("ovf",        32'h3F80_0000, 32'h4348_0000, 32'h7F80_0000, 3'b100, 3,  1'b0);
      run_op("uflow_sat",  32'hBF80_0000, 32'hC3C8_0000, 32'h8000_0000, 3'b010, 3,  1'b0);
      run_op("denorm-3",   32'h3F80_0000, 32'hC302_0000, 32'h0008_0000, 3'b010, 7,  1'b0);
      run_op("denorm-22",  32'h3F80_0000, 32'hC315_0000, 32'h0000_0001, 3'b010, 26, 1'b0);
      run_op("xnan",       32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 3,  1'b0);
      run_op("ninf",       32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001, 3,  1'b0);
      run_op("xinf",       32'hFF80_0000, 32'hC040_0000, 32'hFF80_0000, 3'b000, 3,  1'b0);
      run_op("negzero",    32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 3'b000, 3,  1'b0);
      run_op("subflush",   32'h0000_1234, 32'h4120_0000, 32'h0000_0000, 3'b000, 3,  1'b0);

      // Back-pressure: hold out_ready low; a second in_valid must be ignored.
      in_valid = 1'b1;
      x        = 32'h3FA0_0000;
      n        = 32'h4000_0000;
      @(posedge clk); #1;
      x = 32'h3F80_0000;
      n = 32'h4348_0000;
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk("hold.lat", 32'(cnt), 32'd3);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold.res", result, 32'h40A0_0000);
         chk("hold.flags", 32'({overflow, underflow, invalid}), 32'd0);
         chk("hold.hs", 32'({out_valid, in_ready}), 32'b10);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hold.ret", 32'({out_valid, in_ready}), 32'b01);

      // Async reset during the denorm shift of a long op.
      in_valid = 1'b1;
      x        = 32'h3F80_0000;
      n        = 32'hC315_0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("arst.in_ready", 32'(in_ready), 32'd1);
      chk("arst.out_valid", 32'(out_valid), 32'd0);
      chk("arst.result", result, 32'h0000_0000);
      #2;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("arst.no_out", 32'(seen), 32'd0);
      run_op("post_rst",   32'h3FC8_0000, 32'h40C0_0000, 32'h42C8_0000, 3'b000, 3,  1'b0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/scale_by_pow2.md
# scale_by_pow2

Multi-cycle FP32 recomposition unit computing result = x · 2^n, where x and n arrive as IEEE-754 single-precision values. It is the inverse of the ln argument decomposition (A = x · 2^n, x ∈ [1,2)) and closes the exp/pow path after the polynomial stage. It handles one operation at a time behind valid/ready handshakes. Subnormal results are produced by a serial right-shift.

## Interface
- FLUSH_SUBNORM_IN, default 1, meaning x inputs with exponent field 0 are treated as signed zero.
- N_SAT, default 300, meaning the converted integer n is clamped to [-N_SAT, +N_SAT].
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit idle; equals (state == IDLE).
- x  in  32  FP32 mantissa operand.
- n  in  32  FP32 exponent operand; integer-valued.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  32  FP32 x · 2^n.
- overflow  out  1  result saturated to ±inf.
- underflow  out  1  result is subnormal or zero from a nonzero finite x.
- invalid  out  1  NaN input, or n = ±inf.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, register x and n and go to CONV.
  - CONV: convert n to a signed 11-bit nint. Truncate toward zero, so exp field < 127 gives 0. Clamp to ±N_SAT. Then go to ADD.
  - ADD: resolve specials, else compute e = exp(x) + nint as a signed 11-bit value. Branch to DONE or DENORM.
  - DENORM: per cycle, shift the mantissa (hidden bit restored) right 1 and increment e. When e == 1, emit exponent field 0 and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Specials, decided in ADD, all going straight to DONE:
  - x or n NaN, or n = ±inf: result 0x7FC00000, invalid=1.
  - x = ±inf: ±inf.
  - x = ±0, or subnormal with FLUSH_SUBNORM_IN=1: signed zero, no flags.
- Arithmetic:
  - 1 ≤ e ≤ 254: result = {sx, e[7:0], frac(x)}. Exact, no flags.
  - e ≥ 255: ±inf (0x7F800000 | sign), overflow=1.
  - e ≤ 0 and e ≥ -22: enter DENORM. Shifted-out bits are truncated with no rounding. underflow=1.
  - e < -22: signed zero, underflow=1, no DENORM cycles.
- Outputs result, overflow, underflow and invalid are registered. They are held stable from out_valid rise until the handshake completes.

## Timing
- Reset values: state IDLE, out_valid 0, result 0x00000000, all flags 0, in_ready 1.
- Accept occurs at edge T0 (in_valid & in_ready). CONV runs in T0+1 and ADD in T0+2.
- Normal and special paths: out_valid is high from cycle T0+3.
- Subnormal path: out_valid rises at T0+3+(1−e). The maximum is T0+26, at e = -22.
- in_ready is 0 from T0+1 until the cycle after the out handshake. There is no back-to-back overlap, so minimum throughput is 1 op per 4 cycles.
- out_ready held low: the unit stays in DONE indefinitely with outputs unchanged. in_valid is ignored while not IDLE.
- out_ready may be high before out_valid. The handshake completes on the first DONE cycle.
- Reset asserted mid-operation: the unit returns to reset values immediately (async). The in-flight op is discarded and no out_valid is produced.

## Structure
- Shared package tpu_fp_pkg holds:
  - FP32 field widths.
  - EXP_BIAS=127.
  - QNAN=32'h7FC00000 and POS_INF=32'h7F800000.
  - The state enum {IDLE, CONV, ADD, DENORM, DONE}.
- Sub-module fp32_to_int_trunc (combinational) performs float → saturated signed integer, including its own NaN/inf detect. It is instantiated in CONV. The main FSM, exponent adder and denorm shifter stay in scale_by_pow2.

## Test plan
- x=0x3FA00000 (1.25), n=2.0 → result 0x40A00000 (5.0), out_valid at T0+3, no flags.
- x=1.5625, n=6.0 → 0x42C80000 (100.0). Also x=1.85546875, n=9.0 → 0x446D8000 (950.0).
- x=1.0, n=200.0 → 0x7F800000, overflow=1. x=-1.0, n=-400.0 → 0x80000000, underflow=1 with no DENORM cycles.
- x=1.0, n=-130.0 → 0x00080000, underflow=1, out_valid at T0+7 (e=-3, 4 shift cycles).
- x=0x7FC00000 with n=1.0 → 0x7FC00000, invalid=1. x=1.0 with n=+inf → 0x7FC00000, invalid=1.
- Hold out_ready=0 for 5 cycles → result/flags stable, in_ready=0. Then pulse rst_n low during DENORM of a second op → out_valid never asserts and in_ready=1 immediately.
